// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-line I-cache and a
// single-outstanding refill handshake, producing a registered IF/ID bundle or a bubble.
module if_fetch #(
    parameter int unsigned ICACHE_LINES = 64,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] npc_o,
    output logic [31:0] inst_o,
    output logic [31:0] pred_o
);
    localparam int unsigned IdxW = $clog2(ICACHE_LINES);
    localparam int unsigned TagW = 30 - IdxW;

    typedef enum logic [1:0] {StIdle, StMiss, StDrain} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       addr_q, addr_d;
    logic              req_q, req_d;
    logic [31:0]       out_pc_q, out_pc_d;
    logic [31:0]       out_npc_q, out_npc_d;
    logic [31:0]       out_inst_q, out_inst_d;

    logic [ICACHE_LINES-1:0] valid_q;
    logic [TagW-1:0]         tag_q  [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];

    logic [IdxW-1:0] lk_idx, fill_idx;
    logic [TagW-1:0] lk_tag, fill_tag;
    logic            hit, fill_en;
    logic [31:0]     pc_inc;

    assign lk_idx   = pc_q[IdxW+1:2];
    assign lk_tag   = pc_q[31:IdxW+2];
    assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pc_inc   = pc_q + 32'd4;
    // The refill target is the latched request address, which may differ from pc_q in drain.
    assign fill_en  = req_q & mem_done_i;
    assign fill_idx = addr_q[IdxW+1:2];
    assign fill_tag = addr_q[31:IdxW+2];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        out_pc_d   = out_pc_q;
        out_npc_d  = out_npc_q;
        out_inst_d = out_inst_q;

        if (fill_en) begin
            req_d   = 1'b0;
            state_d = StIdle;
        end

        if (jmp_i) begin
            pc_d       = jmp_addr_i & ~32'd3;
            out_pc_d   = 32'd0;
            out_npc_d  = 32'd0;
            out_inst_d = 32'd0;
            if (state_q == StMiss && !fill_en) begin
                state_d = StDrain;
            end
        end else if (!stall_i) begin
            out_pc_d   = 32'd0;
            out_npc_d  = 32'd0;
            out_inst_d = 32'd0;
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        out_pc_d   = pc_q;
                        out_npc_d  = pc_inc;
                        out_inst_d = data_q[lk_idx];
                        pc_d       = pc_inc;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = StMiss;
                    end
                end
                StMiss: begin
                    if (fill_en) begin
                        out_pc_d   = pc_q;
                        out_npc_d  = pc_inc;
                        out_inst_d = mem_inst_i;
                        pc_d       = pc_inc;
                    end
                end
                StDrain: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            addr_q     <= 32'd0;
            req_q      <= 1'b0;
            out_pc_q   <= 32'd0;
            out_npc_q  <= 32'd0;
            out_inst_q <= 32'd0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            out_pc_q   <= out_pc_d;
            out_npc_q  <= out_npc_d;
            out_inst_q <= out_inst_d;
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_inst_i;
        end
    end

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign pc_o       = out_pc_q;
    assign npc_o      = out_npc_q;
    assign inst_o     = out_inst_q;
    assign pred_o     = out_npc_q;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory-controller model plus an in-order instruction-stream and
// cache-occupancy reference, driven by directed scenarios and a randomized phase.
module tb_if_fetch;
    localparam int unsigned Lines = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        jmp_i = 1'b0;
    logic [31:0] jmp_addr_i = 32'd0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_done_i = 1'b0;
    logic [31:0] mem_inst_i = 32'd0;
    logic [31:0] pc_o, npc_o, inst_o, pred_o;

    if_fetch #(.ICACHE_LINES(Lines), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .jmp_i      (jmp_i),
        .jmp_addr_i (jmp_addr_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_done_i (mem_done_i),
        .mem_inst_i (mem_inst_i),
        .pc_o       (pc_o),
        .npc_o      (npc_o),
        .inst_o     (inst_o),
        .pred_o     (pred_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state
    logic [31:0] exp_pc;
    bit          mdl_valid [Lines];
    logic [31:0] mdl_addr  [Lines];
    bit          busy;
    int          rem;
    logic [31:0] req_addr;
    int unsigned n_reqs, n_emit;
    bit          rand_lat, spurious;
    logic [31:0] prev_pc, prev_inst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) | 32'h3;
    endfunction

    function automatic int unsigned line_of(input logic [31:0] a);
        return (a >> 2) % Lines;
    endfunction

    function automatic bit mdl_hit(input logic [31:0] a);
        return mdl_valid[line_of(a)] && (mdl_addr[line_of(a)] == a);
    endfunction

    task automatic model_reset();
        exp_pc = 32'h0;
        busy = 0;
        for (int i = 0; i < Lines; i++) mdl_valid[i] = 0;
        prev_pc = 32'd0;
        prev_inst = 32'd0;
    endtask

    task automatic step();
        bit          was_done, cj, cs;
        logic [31:0] ct;
        was_done = 0;
        mem_done_i = 1'b0;
        mem_inst_i = $urandom;
        if (busy) begin
            rem--;
            if (rem <= 0) begin
                mem_done_i = 1'b1;
                mem_inst_i = mem_word(req_addr);
                was_done = 1;
            end
        end else if (spurious && $urandom_range(0, 7) == 0) begin
            mem_done_i = 1'b1;
        end
        cj = jmp_i;
        cs = stall_i;
        ct = jmp_addr_i;
        @(posedge clk);
        #1;
        mem_done_i = 1'b0;
        // Memory controller / cache occupancy
        if (was_done) begin
            busy = 0;
            mdl_valid[line_of(req_addr)] = 1;
            mdl_addr[line_of(req_addr)] = req_addr;
            check("req_drop", mem_req_o, 0);
        end else if (busy) begin
            check("addr_hold", mem_addr_o, req_addr);
            check("req_hold", mem_req_o, 1);
        end else if (mem_req_o) begin
            busy = 1;
            rem = rand_lat ? int'($urandom_range(1, 4)) : 3;
            req_addr = mem_addr_o;
            n_reqs++;
            check("req_addr", mem_addr_o, exp_pc);
            check("req_was_miss", {31'd0, mdl_hit(exp_pc)}, 0);
        end
        // Program-order instruction stream
        if (cj) begin
            check("jmp_bubble", inst_o, 0);
            exp_pc = ct & ~32'd3;
        end else if (cs) begin
            check("stall_pc", pc_o, prev_pc);
            check("stall_inst", inst_o, prev_inst);
        end else if (inst_o != 32'd0) begin
            check("emit_pc", pc_o, exp_pc);
            check("emit_inst", inst_o, mem_word(exp_pc));
            check("emit_npc", npc_o, exp_pc + 32'd4);
            check("emit_pred", pred_o, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_emit++;
        end
        prev_pc = pc_o;
        prev_inst = inst_o;
    endtask

    task automatic run_until(input logic [31:0] target, input string tag);
        int k = 0;
        while (exp_pc !== target && k < 200) begin
            step();
            k++;
        end
        check(tag, exp_pc, target);
    endtask

    task automatic jump(input logic [31:0] target);
        jmp_i = 1'b1;
        jmp_addr_i = target;
        step();
        jmp_i = 1'b0;
    endtask

    initial begin
        int unsigned r0, e0;
        int          k;
        n_reqs = 0;
        n_emit = 0;
        rand_lat = 0;
        spurious = 0;
        model_reset();

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc_o, 0);
        check("rst_npc", npc_o, 0);
        check("rst_inst", inst_o, 0);
        check("rst_pred", pred_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_addr", mem_addr_o, 0);
        rst = 1'b1;

        // First miss at reset PC, latency 3
        step();
        check("m1_req", mem_req_o, 1);
        check("m1_addr", mem_addr_o, 0);
        step();
        step();
        check("m1_bubble", inst_o, 0);
        step();
        check("m1_inst", inst_o, mem_word(32'h0));
        check("m1_pc", pc_o, 32'h0);
        check("m1_npc", npc_o, 32'h4);

        // Loop 0x0-0xC twice
        run_until(32'h10, "pass1_done");
        check("pass1_misses", n_reqs, 4);
        jump(32'h0);
        r0 = n_reqs;
        for (int i = 0; i < 4; i++) begin
            step();
            check("pass2_inst", inst_o, mem_word(32'(i * 4)));
            check("pass2_noreq", mem_req_o, 0);
        end
        check("pass2_reqs", n_reqs - r0, 0);

        // Stall during hit stream
        jump(32'h0);
        step();
        step();
        stall_i = 1'b1;
        repeat (3) step();
        stall_i = 1'b0;
        step();
        check("stall_resume_pc", pc_o, 32'h8);
        check("stall_resume_inst", inst_o, mem_word(32'h8));

        // Redirect while miss at 0x20 is outstanding
        jump(32'h20);
        step();
        check("drain_req", mem_req_o, 1);
        jump(32'h100);
        r0 = n_reqs;
        k = 0;
        while (n_reqs == r0 && k < 50) begin
            step();
            k++;
        end
        check("drain_next_req", req_addr, 32'h100);
        run_until(32'h104, "emit_100");

        // 0x100 evicted 0x0
        jump(32'h0);
        step();
        check("alias_req", mem_req_o, 1);
        check("alias_addr", mem_addr_o, 32'h0);
        run_until(32'h4, "alias_refetch");

        // Redirect coincident with stall to cached target
        jump(32'h40);
        run_until(32'h44, "cache_40");
        jmp_i = 1'b1;
        stall_i = 1'b1;
        jmp_addr_i = 32'h40;
        step();
        check("js_bubble", inst_o, 0);
        jmp_i = 1'b0;
        step();
        step();
        stall_i = 1'b0;
        step();
        check("js_pc", pc_o, 32'h40);
        check("js_inst", inst_o, mem_word(32'h40));

        // PC wrap
        jump(32'hFFFF_FFFE);
        run_until(32'h0, "wrap_emit");
        check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        check("wrap_npc", npc_o, 32'h0);
        check("wrap_pred", pred_o, 32'h0);
        run_until(32'h4, "wrap_next");
        check("wrap_next_pc", pc_o, 32'h0);

        // Randomized phase
        rand_lat = 1;
        spurious = 1;
        e0 = n_emit;
        for (int i = 0; i < 2000; i++) begin
            stall_i = ($urandom_range(0, 3) == 0);
            jmp_i = ($urandom_range(0, 15) == 0);
            jmp_addr_i = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom_range(0, 95) << 2);
            step();
        end
        jmp_i = 1'b0;
        stall_i = 1'b0;
        spurious = 0;
        check("rand_progress", {31'd0, (n_emit - e0) > 100}, 1);

        // Reset during an outstanding miss
        jump(32'h3000);
        k = 0;
        while (!(busy && req_addr == 32'h3000) && k < 50) begin
            step();
            k++;
        end
        check("midmiss_reach", req_addr, 32'h3000);
        rst = 1'b0;
        #1;
        check("midmiss_req", mem_req_o, 0);
        check("midmiss_addr", mem_addr_o, 0);
        check("midmiss_inst", inst_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check("post_rst_req", mem_req_o, 1);
        check("post_rst_addr", mem_addr_o, 0);
        run_until(32'h4, "post_rst_emit");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
